// File: rtl/exe_trace_checker_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : exe_trace_checker_pkg                                      |
// | Description : Shared types and constants for the execution-trace         |
// |               checker: the comparison state enum, the mismatch counter   |
// |               width and a saturating increment helper.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package exe_trace_checker_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int MISMATCH_CNT_W = 16;

  // Counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [MISMATCH_CNT_W-1:0] sat_inc(input logic [MISMATCH_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exe_trace_checker_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : exe_trace_checker_if                                       |
// | Description : Trace bus between the stimulus/core side (master) and the  |
// |               checker (slave).                                           |
// |   exe_enable/act_data          : actual entry retired by the core        |
// |   exp_valid/exp_ready          : expected-entry handshake                |
// |   exp_data/exp_mask/exp_last   : expected entry, don't-care bits, final  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface exe_trace_checker_if #(
  parameter int NUM_OF_COLUMNS = 2,
  parameter int DATA_WIDTH     = 32
);
  localparam int ENTRY_W = NUM_OF_COLUMNS * DATA_WIDTH;

  logic               exe_enable;
  logic [ENTRY_W-1:0] act_data;
  logic               exp_valid;
  logic               exp_ready;
  logic [ENTRY_W-1:0] exp_data;
  logic [ENTRY_W-1:0] exp_mask;
  logic               exp_last;

  modport master (
    output exe_enable, act_data, exp_valid, exp_data, exp_mask, exp_last,
    input  exp_ready
  );

  modport slave (
    input  exe_enable, act_data, exp_valid, exp_data, exp_mask, exp_last,
    output exp_ready
  );
endinterface
`default_nettype wire

// File: rtl/exe_trace_checker_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : trace_sync_fifo                                            |
// | Description : Single-clock FIFO buffering actual trace entries.          |
// |   push/wdata  : write request (accepted when not full, or when a pop     |
// |                 happens at the same edge)                                |
// |   pop/rdata   : read request; rdata shows the head entry (no bypass)     |
// |   full/empty/level : occupancy status                                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module trace_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves at the same edge.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset: pointer reset alone discards buffered entries.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end
endmodule
`default_nettype wire

// File: rtl/exe_trace_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : exe_trace_checker                                          |
// | Description : Compares retired execution-trace entries against an       |
// |               expected stream, with per-bit wildcards, pause-on-mismatch |
// |               and first-failure capture.                                 |
// |   clk, reset     : clock, asynchronous active-high reset                 |
// |   bus (slave)    : actual entries in, expected-entry handshake           |
// |   resume         : leave PAUSED                                          |
// |   stall_req      : ask the core to stop retiring                         |
// |   overflow       : sticky, an actual entry was dropped                    |
// |   pass1_fail0    : sticky pass flag                                      |
// |   all_done       : comparison finished                                   |
// |   mismatch_cnt / entry_cnt / first_bad_idx / first_bad_cols : results    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module exe_trace_checker
  import exe_trace_checker_pkg::*;
#(
  parameter int NUM_OF_COLUMNS    = 2,
  parameter int DATA_WIDTH        = 32,
  parameter int FIFO_DEPTH        = 8,
  parameter int PAUSE_ON_MISMATCH = 1,
  parameter int WILDCARD_COMPARE  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  exe_trace_checker_if.slave        bus,
  input  logic                      resume,
  output logic                      stall_req,
  output logic                      overflow,
  output logic                      pass1_fail0,
  output logic                      all_done,
  output logic [MISMATCH_CNT_W-1:0] mismatch_cnt,
  output logic [31:0]               entry_cnt,
  output logic [31:0]               first_bad_idx,
  output logic [NUM_OF_COLUMNS-1:0] first_bad_cols
);
  localparam int ENTRY_W = NUM_OF_COLUMNS * DATA_WIDTH;
  localparam int LW      = $clog2(FIFO_DEPTH) + 1;

  state_e                    state_q, state_d;
  logic                      overflow_q, overflow_d;
  logic                      pass_q, pass_d;
  logic [MISMATCH_CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic [31:0]               entry_cnt_q, entry_cnt_d;
  logic [31:0]               first_bad_idx_q, first_bad_idx_d;
  logic [NUM_OF_COLUMNS-1:0] first_bad_cols_q, first_bad_cols_d;

  logic [ENTRY_W-1:0]        fifo_rdata;
  logic                      fifo_full, fifo_empty;
  logic [LW-1:0]             fifo_level;
  logic                      push_req, handshake, any_mismatch;
  logic [NUM_OF_COLUMNS-1:0] col_mismatch;

  assign push_req      = bus.exe_enable && (state_q != ST_DONE);
  assign bus.exp_ready = (state_q == ST_RUN) && !fifo_empty;
  assign handshake     = bus.exp_valid && bus.exp_ready;

  trace_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .wdata (bus.act_data),
    .pop   (handshake),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  for (genvar c = 0; c < NUM_OF_COLUMNS; c++) begin : g_col
    logic [DATA_WIDTH-1:0] eff_mask;
    // With wildcards disabled the mask is forced to zero: every bit compares.
    assign eff_mask = bus.exp_mask[c*DATA_WIDTH +: DATA_WIDTH]
                    & {DATA_WIDTH{WILDCARD_COMPARE != 0}};
    assign col_mismatch[c] = |((fifo_rdata[c*DATA_WIDTH +: DATA_WIDTH]
                              ^ bus.exp_data[c*DATA_WIDTH +: DATA_WIDTH]) & ~eff_mask);
  end

  assign any_mismatch = |col_mismatch;

  always_comb begin
    state_d          = state_q;
    overflow_d       = overflow_q | (push_req & fifo_full & ~handshake);
    pass_d           = pass_q;
    mismatch_cnt_d   = mismatch_cnt_q;
    entry_cnt_d      = entry_cnt_q;
    first_bad_idx_d  = first_bad_idx_q;
    first_bad_cols_d = first_bad_cols_q;

    if (handshake) begin
      entry_cnt_d = entry_cnt_q + 32'd1;
      if (any_mismatch) begin
        mismatch_cnt_d = sat_inc(mismatch_cnt_q);
        pass_d         = 1'b0;
        // pass_q only ever clears on a mismatch, so it doubles as
        // "no failure captured yet".
        if (pass_q) begin
          first_bad_idx_d  = entry_cnt_q;
          first_bad_cols_d = col_mismatch;
        end
      end
    end

    unique case (state_q)
      ST_RUN: begin
        if (handshake) begin
          // The last entry ends the run even if it also mismatches.
          if (bus.exp_last) begin
            state_d = ST_DONE;
          end else if (any_mismatch && (PAUSE_ON_MISMATCH != 0)) begin
            state_d = ST_PAUSED;
          end
        end
      end
      ST_PAUSED: begin
        if (resume) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_RUN;
      overflow_q       <= 1'b0;
      pass_q           <= 1'b1;
      mismatch_cnt_q   <= '0;
      entry_cnt_q      <= '0;
      first_bad_idx_q  <= '0;
      first_bad_cols_q <= '0;
    end else begin
      state_q          <= state_d;
      overflow_q       <= overflow_d;
      pass_q           <= pass_d;
      mismatch_cnt_q   <= mismatch_cnt_d;
      entry_cnt_q      <= entry_cnt_d;
      first_bad_idx_q  <= first_bad_idx_d;
      first_bad_cols_q <= first_bad_cols_d;
    end
  end

  // Status decoded purely from registered state and FIFO occupancy.
  assign stall_req      = (state_q != ST_DONE)
                        && ((fifo_level >= LW'(FIFO_DEPTH - 1)) || (state_q == ST_PAUSED));
  assign all_done       = (state_q == ST_DONE);
  assign overflow       = overflow_q;
  assign pass1_fail0    = pass_q;
  assign mismatch_cnt   = mismatch_cnt_q;
  assign entry_cnt      = entry_cnt_q;
  assign first_bad_idx  = first_bad_idx_q;
  assign first_bad_cols = first_bad_cols_q;
endmodule
`default_nettype wire
